chip8_mem_arbiter: RTL and testbench

- Shares the single-port CHIP-8 memory BRAM between three requesters: video scan-out, debug/loader, and the chip8_processor.
- Serializes requests, drives the BRAM address/write port, counts out the BRAM read latency, and routes the returned byte with a one-cycle valid pulse to the owning requester.
- Sits between chip8_processor, the video fetch logic and the debug UART bridge on one side, and the memory BRAM on the other.

---
 rtl/chip8_pkg.sv | 20 ++
 rtl/chip8_mem_arbiter_if.sv | 59 +++++
 rtl/chip8_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared types and widths for the CHIP-8 memory arbiter and its requesters.
// Requester identities and arbiter states live here so benches and neighbours agree on them.
package chip8_pkg;

    localparam int CHIP8_ADDR_W = 12;
    localparam int CHIP8_DATA_W = 8;

    typedef enum logic [1:0] {
        REQ_VIDEO,
        REQ_DEBUG,
        REQ_PROC
    } req_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_t;

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Request/response and BRAM-side signals of the CHIP-8 memory arbiter.
// The arbiter takes the slave view; requesters and the BRAM model take the master view.
interface chip8_mem_arbiter_if
    import chip8_pkg::*;
#(
    parameter int ADDR_W = CHIP8_ADDR_W,
    parameter int DATA_W = CHIP8_DATA_W
);

    logic              video_valid_in;
    logic [ADDR_W-1:0] video_addr_in;
    logic              video_ready_out;
    logic              video_valid_out;

    logic              debug_valid_in;
    logic              debug_we_in;
    logic [ADDR_W-1:0] debug_addr_in;
    logic [DATA_W-1:0] debug_data_in;
    logic              debug_ready_out;
    logic              debug_valid_out;

    logic              proc_valid_in;
    logic              proc_we_in;
    logic [ADDR_W-1:0] proc_addr_in;
    logic [DATA_W-1:0] proc_data_in;
    logic              proc_ready_out;
    logic              proc_valid_out;

    logic [ADDR_W-1:0] bram_addr_out;
    logic              bram_we_out;
    logic [DATA_W-1:0] bram_data_out;
    logic [DATA_W-1:0] bram_data_in;
    logic [DATA_W-1:0] data_out;

    modport slave (
        input  video_valid_in, video_addr_in,
        output video_ready_out, video_valid_out,
        input  debug_valid_in, debug_we_in, debug_addr_in, debug_data_in,
        output debug_ready_out, debug_valid_out,
        input  proc_valid_in, proc_we_in, proc_addr_in, proc_data_in,
        output proc_ready_out, proc_valid_out,
        output bram_addr_out, bram_we_out, bram_data_out,
        input  bram_data_in,
        output data_out
    );

    modport master (
        output video_valid_in, video_addr_in,
        input  video_ready_out, video_valid_out,
        output debug_valid_in, debug_we_in, debug_addr_in, debug_data_in,
        input  debug_ready_out, debug_valid_out,
        output proc_valid_in, proc_we_in, proc_addr_in, proc_data_in,
        input  proc_ready_out, proc_valid_out,
        input  bram_addr_out, bram_we_out, bram_data_out,
        output bram_data_in,
        input  data_out
    );

endinterface

// File: rtl/chip8_mem_arbiter.sv
// Single-port BRAM arbiter for video scan-out, debug loader and the CHIP-8 processor.
// One transaction in flight at a time; the owner gets a one-cycle valid pulse on completion.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W       = CHIP8_ADDR_W,
    parameter int DATA_W       = CHIP8_DATA_W,
    parameter int BRAM_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    chip8_mem_arbiter_if.slave  bus
);

    localparam logic [2:0] LAT_LAST   = 3'(BRAM_LATENCY);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    req_t              owner_q, owner_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              bram_we_q, bram_we_d;
    logic [DATA_W-1:0] bram_data_q, bram_data_d;
    logic [DATA_W-1:0] data_q, data_d;

    req_t              grant;
    logic              grant_vld;
    logic              accept;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_data;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        bram_addr_d = bram_addr_q;
        bram_we_d   = 1'b0;
        bram_data_d = bram_data_q;
        data_d      = data_q;
        grant       = REQ_VIDEO;
        grant_vld   = 1'b0;
        req_addr    = '0;
        req_we      = 1'b0;
        req_data    = '0;

        // A starved processor jumps ahead of both other requesters.
        if ((starve_q == STARVE_MAX) && bus.proc_valid_in) begin
            grant     = REQ_PROC;
            grant_vld = 1'b1;
        end else if (bus.video_valid_in) begin
            grant     = REQ_VIDEO;
            grant_vld = 1'b1;
        end else if (bus.debug_valid_in) begin
            grant     = REQ_DEBUG;
            grant_vld = 1'b1;
        end else if (bus.proc_valid_in) begin
            grant     = REQ_PROC;
            grant_vld = 1'b1;
        end

        case (grant)
            REQ_DEBUG: begin
                req_addr = bus.debug_addr_in;
                req_we   = bus.debug_we_in;
                req_data = bus.debug_data_in;
            end
            REQ_PROC: begin
                req_addr = bus.proc_addr_in;
                req_we   = bus.proc_we_in;
                req_data = bus.proc_data_in;
            end
            default: begin
                req_addr = bus.video_addr_in;
                req_we   = 1'b0;
                req_data = '0;
            end
        endcase

        // RESP behaves like IDLE so the next request can overlap the response pulse.
        accept = rst_in && grant_vld && (state_q != ARB_WAIT);

        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                state_d = ARB_IDLE;
                if (accept) begin
                    state_d     = ARB_WAIT;
                    owner_d     = grant;
                    we_d        = req_we;
                    cnt_d       = 3'd0;
                    bram_addr_d = req_addr;
                    bram_we_d   = req_we;
                    bram_data_d = req_data;
                end
            end
            ARB_WAIT: begin
                if (we_q) begin
                    state_d = ARB_RESP;
                end else if (cnt_q == LAT_LAST) begin
                    data_d  = bus.bram_data_in;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (accept) begin
            if (grant == REQ_PROC) begin
                starve_d = 8'd0;
            end else if (bus.proc_valid_in && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ARB_IDLE;
            owner_q     <= REQ_VIDEO;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            starve_q    <= 8'd0;
            bram_addr_q <= '0;
            bram_we_q   <= 1'b0;
            bram_data_q <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            bram_addr_q <= bram_addr_d;
            bram_we_q   <= bram_we_d;
            bram_data_q <= bram_data_d;
            data_q      <= data_d;
        end
    end

    assign bus.video_ready_out = accept && (grant == REQ_VIDEO);
    assign bus.debug_ready_out = accept && (grant == REQ_DEBUG);
    assign bus.proc_ready_out  = accept && (grant == REQ_PROC);

    assign bus.video_valid_out = (state_q == ARB_RESP) && (owner_q == REQ_VIDEO);
    assign bus.debug_valid_out = (state_q == ARB_RESP) && (owner_q == REQ_DEBUG);
    assign bus.proc_valid_out  = (state_q == ARB_RESP) && (owner_q == REQ_PROC);

    assign bus.bram_addr_out = bram_addr_q;
    assign bus.bram_we_out   = bram_we_q;
    assign bus.bram_data_out = bram_data_q;
    assign bus.data_out      = data_q;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: table vectors, directed corner sequences and random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_chip8_mem_arbiter;
    import chip8_pkg::*;

    localparam int AW   = 12;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int SLIM = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    chip8_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    chip8_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BRAM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) u_dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus2.slave)
    );

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BRAM_LATENCY(1), .STARVE_LIMIT(SLIM)) u_dut_lat1 (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus1.slave)
    );

    // Behavioural BRAM stand-ins, preloaded with mem[a] = a*37.
    logic [7:0] mem2 [4096];
    logic [7:0] pipe2 [LAT];
    bit         mem2_init = 1'b0;
    always @(posedge clk) begin
        if (!mem2_init) begin
            for (int a = 0; a < 4096; a++) mem2[a] <= 8'(a * 37);
            mem2_init <= 1'b1;
        end else if (bus2.bram_we_out) begin
            mem2[bus2.bram_addr_out] <= bus2.bram_data_out;
        end
        pipe2[0] <= mem2[bus2.bram_addr_out];
        for (int i = 1; i < LAT; i++) pipe2[i] <= pipe2[i-1];
    end
    assign bus2.bram_data_in = pipe2[LAT-1];

    logic [7:0] mem1 [4096];
    logic [7:0] pipe1;
    bit         mem1_init = 1'b0;
    always @(posedge clk) begin
        if (!mem1_init) begin
            for (int a = 0; a < 4096; a++) mem1[a] <= 8'(a * 37);
            mem1_init <= 1'b1;
        end else if (bus1.bram_we_out) begin
            mem1[bus1.bram_addr_out] <= bus1.bram_data_out;
        end
        pipe1 <= mem1[bus1.bram_addr_out];
    end
    assign bus1.bram_data_in = pipe1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;
    bit auto_drop = 1'b0;
    bit keep_v = 1'b0;

    // Transaction-level model state.
    logic [7:0]  ref_mem [4096];
    int          free_at, resp_cyc, resp_own, we_cyc, starve;
    bit          resp_rd;
    logic [7:0]  resp_data, exp_dout, exp_bdata;
    logic [11:0] exp_addr;

    logic [2:0]  last_rdy, last_vout;
    logic [7:0]  last_dout;
    logic [63:0] last_tuple;

    typedef struct packed {
        logic [2:0]  vld;
        logic        d_we;
        logic        p_we;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [2:0]  exp_rdy;
        logic [7:0]  exp_dout;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        free_at   = cyc;
        resp_own  = -1;
        resp_cyc  = -1;
        we_cyc    = -1;
        starve    = 0;
        exp_dout  = 8'h00;
        exp_addr  = 12'h000;
        exp_bdata = 8'h00;
    endtask

    task automatic step(output logic [2:0] acc);
        logic [2:0]  vld, er, ev;
        logic [63:0] e;
        logic [11:0] ad;
        logic [7:0]  wd;
        logic        w;
        logic        rst_seen;
        int          own;
        @(negedge clk);
        vld       = {bus2.video_valid_in, bus2.debug_valid_in, bus2.proc_valid_in};
        last_rdy  = {bus2.video_ready_out, bus2.debug_ready_out, bus2.proc_ready_out};
        last_vout = {bus2.video_valid_out, bus2.debug_valid_out, bus2.proc_valid_out};
        last_dout = bus2.data_out;
        acc       = vld & last_rdy;
        last_tuple = {29'd0, last_rdy, last_vout, bus2.bram_addr_out, bus2.bram_we_out,
                      bus2.bram_data_out, bus2.data_out};
        if (mon_en) begin
            ev = 3'b000;
            if (resp_own >= 0 && resp_cyc == cyc) begin
                ev = 3'b100 >> resp_own;
                if (resp_rd) exp_dout = resp_data;
                resp_own = -1;
            end
            er = 3'b000;
            if (rst_n && cyc >= free_at) begin
                if (starve == SLIM && vld[0]) er = 3'b001;
                else if (vld[2])              er = 3'b100;
                else if (vld[1])              er = 3'b010;
                else if (vld[0])              er = 3'b001;
            end
            e = {29'd0, er, ev, exp_addr, (we_cyc == cyc), exp_bdata, exp_dout};
            check("cycle_outputs", last_tuple, e);
            if (er != 3'b000) begin
                own = er[2] ? 0 : (er[1] ? 1 : 2);
                if (own == 0) begin
                    ad = bus2.video_addr_in; wd = 8'h00; w = 1'b0;
                end else if (own == 1) begin
                    ad = bus2.debug_addr_in; wd = bus2.debug_data_in; w = bus2.debug_we_in;
                end else begin
                    ad = bus2.proc_addr_in; wd = bus2.proc_data_in; w = bus2.proc_we_in;
                end
                exp_addr  = ad;
                exp_bdata = wd;
                we_cyc    = w ? cyc + 1 : -1;
                free_at   = cyc + (w ? 2 : LAT + 2);
                resp_cyc  = free_at;
                resp_own  = own;
                resp_rd   = !w;
                resp_data = ref_mem[ad];
                if (w) ref_mem[ad] = wd;
                if (own == 2) starve = 0;
                else if (vld[0] && starve < SLIM) starve++;
            end
        end
        @(posedge clk);
        rst_seen = rst_n;
        #1;
        cyc++;
        if (!rst_seen) model_reset();
        if (auto_drop) begin
            if (acc[2] && !keep_v) bus2.video_valid_in = 1'b0;
            if (acc[1]) bus2.debug_valid_in = 1'b0;
            if (acc[0]) bus2.proc_valid_in  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        logic [2:0] a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] acc;
        int         n_p, n_acc, vcount;
        int         pc [3];
        logic [2:0] po [3];
        logic [7:0] pd [2];
        bit         acc_now;

        for (int a = 0; a < 4096; a++) ref_mem[a] = 8'(a * 37);
        vecs[0] = '{3'b100, 1'b0, 1'b0, 12'h201, 8'h00, 3'b100, 8'h25};
        vecs[1] = '{3'b010, 1'b0, 1'b0, 12'h002, 8'h00, 3'b010, 8'h4A};
        vecs[2] = '{3'b001, 1'b0, 1'b0, 12'h200, 8'h00, 3'b001, 8'h00};
        vecs[3] = '{3'b010, 1'b1, 1'b0, 12'h300, 8'hA5, 3'b010, 8'h00};
        vecs[4] = '{3'b001, 1'b0, 1'b0, 12'h300, 8'h00, 3'b001, 8'hA5};
        vecs[5] = '{3'b111, 1'b0, 1'b0, 12'h003, 8'h00, 3'b100, 8'h6F};
        vecs[6] = '{3'b011, 1'b0, 1'b0, 12'h004, 8'h00, 3'b010, 8'h94};
        vecs[7] = '{3'b101, 1'b0, 1'b0, 12'h105, 8'h00, 3'b100, 8'hB9};
        vecs[8] = '{3'b001, 1'b0, 1'b1, 12'h310, 8'h3C, 3'b001, 8'hB9};
        vecs[9] = '{3'b100, 1'b0, 1'b0, 12'h310, 8'h00, 3'b100, 8'h3C};

        rst_n = 1'b0;
        bus2.video_valid_in = 1'b0; bus2.video_addr_in = '0;
        bus2.debug_valid_in = 1'b0; bus2.debug_we_in = 1'b0; bus2.debug_addr_in = '0; bus2.debug_data_in = '0;
        bus2.proc_valid_in  = 1'b0; bus2.proc_we_in  = 1'b0; bus2.proc_addr_in  = '0; bus2.proc_data_in  = '0;
        bus1.video_valid_in = 1'b0; bus1.video_addr_in = '0;
        bus1.debug_valid_in = 1'b0; bus1.debug_we_in = 1'b0; bus1.debug_addr_in = '0; bus1.debug_data_in = '0;
        bus1.proc_valid_in  = 1'b0; bus1.proc_we_in  = 1'b0; bus1.proc_addr_in  = '0; bus1.proc_data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;
        step(acc);
        check("reset_lat1_outputs",
              {35'd0, bus1.video_ready_out, bus1.debug_ready_out, bus1.proc_ready_out,
               bus1.video_valid_out, bus1.debug_valid_out, bus1.proc_valid_out,
               bus1.bram_addr_out, bus1.bram_we_out, bus1.bram_data_out, bus1.data_out}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Table vectors: one cycle of requests, then wait for the owner's pulse.
        for (int k = 0; k < 10; k++) begin
            bus2.video_valid_in = vecs[k].vld[2];
            bus2.debug_valid_in = vecs[k].vld[1];
            bus2.proc_valid_in  = vecs[k].vld[0];
            bus2.video_addr_in  = vecs[k].addr;
            bus2.debug_addr_in  = vecs[k].addr;
            bus2.proc_addr_in   = vecs[k].addr;
            bus2.debug_data_in  = vecs[k].wdata;
            bus2.proc_data_in   = vecs[k].wdata;
            bus2.debug_we_in    = vecs[k].d_we;
            bus2.proc_we_in     = vecs[k].p_we;
            step(acc);
            check("tbl_ready", 64'(last_rdy), 64'(vecs[k].exp_rdy));
            bus2.video_valid_in = 1'b0;
            bus2.debug_valid_in = 1'b0;
            bus2.proc_valid_in  = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step(acc);
                if (last_vout != 3'b000) break;
            end
            check("tbl_resp", {53'd0, last_vout, last_dout}, {53'd0, vecs[k].exp_rdy, vecs[k].exp_dout});
            idle(1);
        end
        bus2.debug_we_in = 1'b0;
        bus2.proc_we_in  = 1'b0;

        // All three request together: grants in priority order, pulses 4 cycles apart.
        auto_drop = 1'b1;
        bus2.video_addr_in = 12'h201; bus2.debug_addr_in = 12'h002; bus2.proc_addr_in = 12'h003;
        bus2.video_valid_in = 1'b1; bus2.debug_valid_in = 1'b1; bus2.proc_valid_in = 1'b1;
        n_p = 0;
        for (int i = 0; i < 40 && n_p < 3; i++) begin
            step(acc);
            check("single_ready", 64'($countones(last_rdy) > 1), 64'd0);
            if (last_vout != 3'b000) begin
                pc[n_p] = i;
                po[n_p] = last_vout;
                n_p++;
            end
        end
        check("trio_count", 64'(n_p), 64'd3);
        check("trio_order", {55'd0, po[0], po[1], po[2]}, {55'd0, 9'b100_010_001});
        check("trio_gap01", 64'(pc[1] - pc[0]), 64'd4);
        check("trio_gap12", 64'(pc[2] - pc[1]), 64'd4);
        idle(3);

        // Video hammering while proc waits: proc wins after exactly SLIM video grants.
        keep_v = 1'b1;
        bus2.video_addr_in = 12'h201; bus2.proc_addr_in = 12'h202;
        bus2.video_valid_in = 1'b1; bus2.proc_valid_in = 1'b1;
        vcount = 0;
        acc = 3'b000;
        for (int i = 0; i < 200; i++) begin
            step(acc);
            if (acc[2]) vcount++;
            if (acc[0]) break;
        end
        check("starve_proc_grant", 64'(acc), 64'd1);
        check("starve_video_grants", 64'(vcount), 64'(SLIM));
        acc = 3'b000;
        for (int i = 0; i < 20 && acc == 3'b000; i++) step(acc);
        check("starve_video_resumes", 64'(acc), 64'b100);
        keep_v = 1'b0;
        bus2.video_valid_in = 1'b0;
        idle(8);

        // Reset lands on an in-flight proc read: it is dropped without a response.
        bus2.proc_addr_in = 12'h200; bus2.proc_we_in = 1'b0; bus2.proc_valid_in = 1'b1;
        step(acc);
        check("rst_first_accept", 64'(acc), 64'd1);
        step(acc);
        rst_n = 1'b0;
        step(acc);
        rst_n = 1'b1;
        step(acc);
        check("rst_outputs_zero", last_tuple, 64'd0);
        bus2.proc_addr_in = 12'h201; bus2.proc_valid_in = 1'b1;
        step(acc);
        check("rst_new_accept", 64'(acc), 64'd1);
        n_p = 0;
        pd[0] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(acc);
            if (last_vout[0]) begin
                n_p++;
                pd[0] = last_dout;
            end
        end
        check("rst_proc_pulses", 64'(n_p), 64'd1);
        check("rst_proc_data", 64'(pd[0]), 64'h25);

        // Latency-1 build: back-to-back proc reads complete 3 cycles apart.
        bus1.proc_addr_in = 12'h200; bus1.proc_valid_in = 1'b1;
        n_p = 0; n_acc = 0;
        pc[0] = 0; pc[1] = 0; pd[0] = 8'h00; pd[1] = 8'h00;
        for (int i = 0; i < 25 && n_p < 2; i++) begin
            @(negedge clk);
            acc_now = bus1.proc_valid_in && bus1.proc_ready_out;
            if (acc_now) n_acc++;
            if (bus1.proc_valid_out) begin
                pc[n_p] = i;
                pd[n_p] = bus1.data_out;
                n_p++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (n_acc == 1) bus1.proc_addr_in = 12'h201;
                else            bus1.proc_valid_in = 1'b0;
            end
        end
        bus1.proc_valid_in = 1'b0;
        check("lat1_pulses", 64'(n_p), 64'd2);
        check("lat1_data0", 64'(pd[0]), 64'h00);
        check("lat1_data1", 64'(pd[1]), 64'h25);
        check("lat1_gap", 64'(pc[1] - pc[0]), 64'd3);

        // Random traffic against the model, including requests withdrawn before acceptance.
        for (int i = 0; i < 1500; i++) begin
            if (!bus2.video_valid_in) begin
                if ($urandom_range(2) == 0) begin
                    bus2.video_valid_in = 1'b1;
                    bus2.video_addr_in  = 12'h200 | 12'($urandom_range(31));
                end
            end else if ($urandom_range(15) == 0) begin
                bus2.video_valid_in = 1'b0;
            end
            if (!bus2.debug_valid_in) begin
                if ($urandom_range(2) == 0) begin
                    bus2.debug_valid_in = 1'b1;
                    bus2.debug_we_in    = 1'($urandom_range(1));
                    bus2.debug_addr_in  = 12'h200 | 12'($urandom_range(31));
                    bus2.debug_data_in  = 8'($urandom);
                end
            end else if ($urandom_range(15) == 0) begin
                bus2.debug_valid_in = 1'b0;
            end
            if (!bus2.proc_valid_in) begin
                if ($urandom_range(2) == 0) begin
                    bus2.proc_valid_in = 1'b1;
                    bus2.proc_we_in    = 1'($urandom_range(1));
                    bus2.proc_addr_in  = 12'h200 | 12'($urandom_range(31));
                    bus2.proc_data_in  = 8'($urandom);
                end
            end else if ($urandom_range(15) == 0) begin
                bus2.proc_valid_in = 1'b0;
            end
            step(acc);
        end
        bus2.video_valid_in = 1'b0;
        bus2.debug_valid_in = 1'b0;
        bus2.proc_valid_in  = 1'b0;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
